// File: rtl/uart_led_frame_parser.sv
// Purpose : decode SYNC/BASE/LEN/DATA/CSUM LED update frames from the UART byte stream
//           and write the pixel bytes into the LED frame memory.
// Latency : o_wr_en / o_frame_done / o_frame_err are registered, 1 cycle after the causing i_stb.
// Backpressure: none; a byte is accepted on every i_stb, including back-to-back strobes.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_stb, i_data          byte strobe and byte from the UART receiver
//   o_wr_en/addr/data      one-cycle write into the LED frame memory
//   o_frame_done           one-cycle pulse, frame ended with a matching checksum
//   o_frame_err            one-cycle pulse, checksum mismatch or inter-byte timeout
//   o_busy                 high while a frame is being received
module uart_led_frame_parser #(
    parameter int         NUM_LEDS       = 64,
    parameter int         ADDR_W         = 6,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 8680,
    parameter int         TIMEOUT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    input  logic [7:0]        i_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BASE,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    localparam logic [9:0]           NUM_LEDS_V = 10'(NUM_LEDS);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q,   state_d;
    logic [8:0]           idx_q,     idx_d;     // base + k, 9 bits so it never wraps
    logic [7:0]           rem_q,     rem_d;     // data bytes still expected
    logic [7:0]           csum_q,    csum_d;
    logic [TIMEOUT_W-1:0] tmo_q,     tmo_d;
    logic                 wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 done_q,    done_d;
    logic                 err_q,     err_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (i_stb) begin
            // A byte always wins over a coincident timeout terminal count.
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (i_data == SYNC_BYTE) state_d = S_BASE;
                end
                S_BASE: begin
                    idx_d   = {1'b0, i_data};
                    csum_d  = i_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    rem_d   = i_data;
                    csum_d  = csum_q ^ i_data;
                    state_d = (i_data == 8'd0) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    csum_d = csum_q ^ i_data;
                    // Out-of-range bytes are consumed and checksummed but not written.
                    if ({1'b0, idx_q} < NUM_LEDS_V) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q[ADDR_W-1:0];
                        wr_data_d = i_data;
                    end
                    idx_d = idx_q + 9'd1;
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = S_CSUM;
                end
                S_CSUM: begin
                    if (i_data == csum_q) done_d = 1'b1;
                    else                  err_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TIMEOUT_W'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule
